in_fifo: RTL and testbench

IN_FIFO -- requirements
Module: in_fifo

---
 rtl/in_fifo_pkg.sv | 15 +
 rtl/in_fifo_mem.sv | 29 ++
 rtl/in_fifo.sv | 91 +++++++++
 tb/tb_in_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/in_fifo_pkg.sv
// Shared constants and pointer typing for the in_fifo codebase slice.
package in_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 8;

    // Pointer width for a given depth: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointer type for a FIFO built with the default depth.
    typedef logic [$clog2(DEPTH_DEF):0] ptr_t;

endpackage : in_fifo_pkg

// File: rtl/in_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module in_fifo_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry on a qualified push.
    // NOTE: storage has no reset; emptiness is tracked purely by the pointers,
    // so clearing the array would cost a reset net on every bit for no benefit.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read gives first-word-fall-through at the head pointer.
    assign o_rdata = r_mem[i_raddr];

endmodule : in_fifo_mem

// File: rtl/in_fifo.sv
// First-word-fall-through input FIFO: pointer, count and handshake logic.
// All status outputs are decoded from the pointer registers only, so there
// is no combinational path from in_valid/out_ready to in_ready/out_valid.
module in_fifo
    import in_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AFULL_LVL  = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    afull
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            PW        = ptr_width(DEPTH);
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LVL);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Full: same index, opposite wrap bit. Empty: identical pointers.
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Occupancy falls out of modulo-2*DEPTH pointer subtraction.
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = w_count;
    assign afull     = (w_count >= AFULL_THR);
    assign out_data  = w_rd_data;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign w_push = in_valid && !w_full;
    assign w_pop  = out_ready && !w_empty;

    // A flushed push must not land in storage either.
    assign w_we = w_push && !flush;

    // Pointer update: reset and flush clear both, otherwise advance on handshakes.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    in_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_data)
    );

endmodule : in_fifo

// File: tb/tb_in_fifo.sv
// Self-checking bench for in_fifo against a queue-based reference model.
module tb_in_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = DEPTH - 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [3:0]    count;
    logic          afull;

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO contents, oldest first.
    logic [DW-1:0] q[$];

    in_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count),
        .afull     (afull)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, step past the edge, then update the model.
    task automatic cycle(input logic v, input logic [DW-1:0] d,
                         input logic r, input logic f);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        do_push   = v && (q.size() < DEPTH);
        do_pop    = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        q.delete();
        #2;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", afull); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (count !== 4'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset got count=%0d ov=%b exp count=0 ov=0", count, out_valid);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] w = 32'hA5A5_0001;
        in_valid = 1'b1; in_data = w;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_bypass out_valid got=%b exp=0", out_valid); end
        cycle(1'b1, w, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_ov got=%b exp=1", out_valid); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            total++; if (out_data !== w || out_valid !== 1'b1) begin
                bad++; $display("FAIL single_hold[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, w);
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL single_drain got ov=%b count=%0d exp ov=0 count=0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
            total++; if (afull !== (q.size() >= AFULL)) begin
                bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, afull, q.size() >= AFULL);
            end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        cycle(1'b1, 32'hDEAD_0009, 1'b0, 1'b0);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ninth_count got=%0d exp=8", count); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL ninth_head got=%h exp=0", out_data); end
    endtask

    task automatic test_full_pop();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h0000_0077;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready_pre got=%b exp=0", in_ready); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL full_pop_data got=%h exp=0", out_data); end
        cycle(1'b1, 32'h0000_0077, 1'b1, 1'b0);
        total++; if (count !== 4'd7) begin bad++; $display("FAIL full_pop_count got=%0d exp=7", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready_post got=%b exp=1", in_ready); end
        // Drain and confirm the remaining order 1..7.
        while (q.size() != 0) begin
            logic [DW-1:0] e = q[0];
            total++; if (out_data !== e) begin bad++; $display("FAIL drain_order got=%h exp=%h", out_data, e); end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 100; i++) begin
            logic          v = 1'($urandom_range(0, 1));
            logic          r = 1'($urandom_range(0, 1));
            logic [DW-1:0] d = $urandom;
            if (r && q.size() != 0) begin
                logic [DW-1:0] e = q[0];
                total++; if (out_data !== e) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, out_data, e); end
            end
            cycle(v, d, r, 1'b0);
            total++; if (count !== 4'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)) begin
                bad++; $display("FAIL rand_state[%0d] got count=%0d ov=%b ir=%b exp count=%0d", i, count, out_valid, in_ready, q.size());
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h5000_0000 + DW'(i), 1'b0, 1'b0);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        total++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got count=%0d ov=%b ir=%b exp 0/0/1", count, out_valid, in_ready);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        total++; if (count !== 4'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_nostore got count=%0d ov=%b exp 0/0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000_0000 + DW'(i), 1'b0, 1'b0);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL rmid_pre_count got=%0d exp=3", count); end
        #2 reset_n = 1'b0;
        q.delete();
        #1;
        total++; if (out_valid !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL rmid_async got ov=%b count=%0d exp 0/0", out_valid, count);
        end
        total++; if (in_ready !== 1'b1 || afull !== 1'b0) begin
            bad++; $display("FAIL rmid_flags got ir=%b af=%b exp 1/0", in_ready, afull);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (count !== 4'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_release got count=%0d ov=%b exp 0/0", count, out_valid);
        end
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
            bad++; $display("FAIL rmid_push got ov=%b data=%h exp 1/12345678", out_valid, out_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL rmid_pop got ov=%b count=%0d exp 0/0", out_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_in_fifo
